// File: rtl/vx_ibuffer_rr.sv
// vx_ibuffer_rr: per-warp instruction FIFOs feeding decode through a round-robin arbiter.
// Define IBUF_BYPASS_EN to let an empty buffer forward the incoming instruction in the same cycle.
module vx_ibuffer_rr #(
   parameter int NUM_WARPS   = 4,
   parameter int NUM_THREADS = 4,
   parameter int DEPTH       = 2,
   parameter int PC_BITS     = 30,
   parameter int UUID_WIDTH  = 1,
   parameter int NW_WIDTH    = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [NW_WIDTH-1:0]    in_wid,
   input  logic [PC_BITS-1:0]     in_pc,
   input  logic [NUM_THREADS-1:0] in_tmask,
   input  logic [31:0]            in_instr,
   input  logic [UUID_WIDTH-1:0]  in_uuid,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [NW_WIDTH-1:0]    out_wid,
   output logic [PC_BITS-1:0]     out_pc,
   output logic [NUM_THREADS-1:0] out_tmask,
   output logic [31:0]            out_instr,
   output logic [UUID_WIDTH-1:0]  out_uuid,
   output logic [NUM_WARPS-1:0]   ibuf_pop,
   output logic [NUM_WARPS-1:0]   empty_mask
);
   localparam int DW = UUID_WIDTH + 32 + NUM_THREADS + PC_BITS;
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [DW-1:0]        mem [NUM_WARPS][DEPTH];
   logic [PW-1:0]        wr_ptr [NUM_WARPS];
   logic [PW-1:0]        rd_ptr [NUM_WARPS];
   logic [CW-1:0]        count [NUM_WARPS];
   logic [NW_WIDTH-1:0]  rr_ptr, grant;
   logic [NUM_WARPS-1:0] push_vec, pop_vec;
   logic                 push, pop, bypass;

   function automatic logic [NW_WIDTH-1:0] wrap_wid(input logic [NW_WIDTH-1:0] w, input int i);
      return NW_WIDTH'((int'(w) + i) % NUM_WARPS);
   endfunction

   function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      empty_mask = '0;
      for (int w = 0; w < NUM_WARPS; w++) empty_mask[w] = count[w] == '0;
   end

   // Scan backwards so the last hit is the first non-empty warp at or after rr_ptr.
   always_comb begin
      grant = rr_ptr;
      for (int i = NUM_WARPS - 1; i >= 0; i--)
         if (!empty_mask[wrap_wid(rr_ptr, i)]) grant = wrap_wid(rr_ptr, i);
   end

`ifdef IBUF_BYPASS_EN
   assign bypass = in_valid && (&empty_mask);
`else
   assign bypass = 1'b0;
`endif

   assign in_ready  = count[in_wid] != CW'(DEPTH);
   assign out_valid = !(&empty_mask) || bypass;
   assign out_wid   = bypass ? in_wid : grant;
   assign {out_uuid, out_instr, out_tmask, out_pc} = bypass ? {in_uuid, in_instr, in_tmask, in_pc}
                                                            : mem[grant][rd_ptr[grant]];
   assign pop       = out_valid && out_ready;
   assign push      = in_valid && in_ready && !(bypass && out_ready);
   assign ibuf_pop  = NUM_WARPS'(pop) << out_wid;
   assign push_vec  = NUM_WARPS'(push) << in_wid;
   assign pop_vec   = NUM_WARPS'(pop && !bypass) << grant;

   // A stalled grant parks rr_ptr on itself so later pushes cannot steal the slot.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr <= '0;
         for (int w = 0; w < NUM_WARPS; w++) begin
            count[w]  <= '0;
            wr_ptr[w] <= '0;
            rd_ptr[w] <= '0;
         end
      end else begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            if (push_vec[w]) wr_ptr[w] <= inc_ptr(wr_ptr[w]);
            if (pop_vec[w]) rd_ptr[w] <= inc_ptr(rd_ptr[w]);
            count[w] <= count[w] + CW'(push_vec[w]) - CW'(pop_vec[w]);
         end
         if (pop) rr_ptr <= wrap_wid(out_wid, 1);
         else if (out_valid) rr_ptr <= out_wid;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[in_wid][wr_ptr[in_wid]] <= {in_uuid, in_instr, in_tmask, in_pc};
   end

   a_wid_range: assert property (@(posedge clk) disable iff (!reset_n) in_valid |-> int'(in_wid) < NUM_WARPS);
   a_pop_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(ibuf_pop));
endmodule

// File: tb/tb_vx_ibuffer_rr.sv
// tb_vx_ibuffer_rr: directed and randomized checks of vx_ibuffer_rr against a queue-based model.
module tb_vx_ibuffer_rr;
   localparam int NW = 4;
   localparam int D  = 2;
   localparam int DW = 1 + 32 + 4 + 30;

   logic clk = 1'b0;
   logic reset_n;
   logic in_valid, in_ready, out_valid, out_ready;
   logic [1:0] in_wid, out_wid;
   logic [29:0] in_pc, out_pc;
   logic [3:0] in_tmask, out_tmask, ibuf_pop, empty_mask;
   logic [31:0] in_instr, out_instr;
   logic [0:0] in_uuid, out_uuid;
   wire [DW-1:0] in_data  = {in_uuid, in_instr, in_tmask, in_pc};
   wire [DW-1:0] out_data = {out_uuid, out_instr, out_tmask, out_pc};

   int errs = 0, chks = 0;
   logic [DW-1:0] q [NW][$];
   int rr, held_w, e_wid;
   bit held_v, e_valid, e_ready, e_byp, e_pop;
   logic [DW-1:0] e_data;
   logic [3:0] e_ibuf, e_empty;

   always #5 clk = ~clk;

   vx_ibuffer_rr dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_wid(in_wid),
      .in_pc(in_pc), .in_tmask(in_tmask), .in_instr(in_instr), .in_uuid(in_uuid),
      .out_valid(out_valid), .out_ready(out_ready), .out_wid(out_wid), .out_pc(out_pc),
      .out_tmask(out_tmask), .out_instr(out_instr), .out_uuid(out_uuid),
      .ibuf_pop(ibuf_pop), .empty_mask(empty_mask)
   );

   task automatic model_reset();
      for (int w = 0; w < NW; w++) q[w].delete();
      rr = 0;
      held_v = 0;
      held_w = 0;
   endtask

   task automatic eval_model();
      bit all_empty;
      int g;
      all_empty = 1;
      for (int w = 0; w < NW; w++) begin
         e_empty[w] = q[w].size() == 0;
         if (q[w].size() != 0) all_empty = 0;
      end
      e_ready = q[in_wid].size() < D;
      e_byp = 0;
`ifdef IBUF_BYPASS_EN
      e_byp = all_empty && in_valid;
`endif
      e_valid = !all_empty || e_byp;
      g = rr;
      if (held_v) g = held_w;
      else
         for (int i = 0; i < NW; i++)
            if (q[(rr + i) % NW].size() != 0) begin
               g = (rr + i) % NW;
               break;
            end
      e_wid = e_byp ? int'(in_wid) : g;
      e_data = e_byp ? in_data : (all_empty ? 'x : q[g][0]);
      e_pop = e_valid && out_ready;
      e_ibuf = e_pop ? 4'(1 << e_wid) : 4'b0;
   endtask

   task automatic update_model();
      if (e_pop && !e_byp) void'(q[e_wid].pop_front());
      if (in_valid && e_ready && !(e_byp && out_ready)) q[in_wid].push_back(in_data);
      if (e_pop) rr = (e_wid + 1) % NW;
      held_v = e_valid && !out_ready;
      held_w = e_wid;
   endtask

   task automatic drive(input bit v, input int w, input logic [29:0] pc, input bit rdy);
      in_valid = v;
      in_wid = 2'(w);
      in_pc = pc;
      in_tmask = 4'($urandom);
      in_instr = $urandom;
      in_uuid = 1'($urandom);
      out_ready = rdy;
      @(negedge clk);
      eval_model();
   endtask

   task automatic tick();
      @(posedge clk);
      update_model();
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      model_reset();
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b1;
      in_valid = 1'b0;
      in_wid = '0;
      in_pc = '0;
      in_tmask = '0;
      in_instr = '0;
      in_uuid = '0;
      out_ready = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      chks++; if (empty_mask !== 4'hf) begin errs++; $display("FAIL reset_empty: got %b want 1111", empty_mask); end
      chks++; if (ibuf_pop !== 4'h0) begin errs++; $display("FAIL reset_pop: got %b want 0000", ibuf_pop); end
      chks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", in_ready); end
      model_reset();
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic test_basic();
      do_reset();
      drive(1, 1, 30'h100, 0); tick();
      drive(0, 0, 30'h0, 1);
      chks++; if (out_valid !== 1'b1 || out_wid !== 2'd1 || out_pc !== 30'h100)
         begin errs++; $display("FAIL basic_out: got v=%b wid=%0d pc=%h want v=1 wid=1 pc=100", out_valid, out_wid, out_pc); end
      chks++; if (ibuf_pop !== 4'b0010) begin errs++; $display("FAIL basic_pop: got %b want 0010", ibuf_pop); end
      tick();
      drive(0, 0, 30'h0, 1);
      chks++; if (out_valid !== 1'b0 || empty_mask !== 4'hf)
         begin errs++; $display("FAIL basic_drained: got v=%b empty=%b want v=0 empty=1111", out_valid, empty_mask); end
      tick();
   endtask

   task automatic test_full();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         drive(1, 2, 30'h200 + 30'(k), 0);
         chks++; if (in_ready !== (k < 2)) begin errs++; $display("FAIL full_ready%0d: got %b want %b", k, in_ready, k < 2); end
         if (k == 2) begin
            chks++; if (empty_mask !== 4'b1011) begin errs++; $display("FAIL full_empty: got %b want 1011", empty_mask); end
         end
         tick();
      end
      for (int k = 0; k < 2; k++) begin
         drive(0, 0, 30'h0, 1);
         chks++; if (out_valid !== 1'b1 || out_wid !== 2'd2 || out_pc !== 30'h200 + 30'(k))
            begin errs++; $display("FAIL full_drain%0d: got v=%b wid=%0d pc=%h want wid=2 pc=%h", k, out_valid, out_wid, out_pc, 30'h200 + 30'(k)); end
         tick();
      end
   endtask

   task automatic test_rr();
      int order [3] = '{0, 1, 3};
      do_reset();
      for (int k = 0; k < 3; k++) begin drive(1, order[k], 30'h300 + 30'(order[k]), 0); tick(); end
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 30'h0, 1);
         chks++; if (out_valid !== 1'b1 || out_wid !== 2'(order[k]) || out_pc !== 30'h300 + 30'(order[k]))
            begin errs++; $display("FAIL rr_grant%0d: got v=%b wid=%0d pc=%h want wid=%0d", k, out_valid, out_wid, out_pc, order[k]); end
         tick();
      end
      drive(0, 0, 30'h0, 1);
      chks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rr_idle: got %b want 0", out_valid); end
      tick();
   endtask

   task automatic test_full_push_pop();
      do_reset();
      drive(1, 0, 30'h400, 0); tick();
      drive(1, 0, 30'h401, 0); tick();
      drive(1, 0, 30'h402, 1);
      chks++; if (in_ready !== 1'b0 || ibuf_pop !== 4'b0001 || out_pc !== 30'h400)
         begin errs++; $display("FAIL fpp_cycle: got rdy=%b pop=%b pc=%h want rdy=0 pop=0001 pc=400", in_ready, ibuf_pop, out_pc); end
      tick();
      drive(0, 0, 30'h0, 1);
      chks++; if (empty_mask[0] !== 1'b0 || out_pc !== 30'h401 || ibuf_pop !== 4'b0001)
         begin errs++; $display("FAIL fpp_second: got empty=%b pc=%h pop=%b want pc=401 pop=0001", empty_mask, out_pc, ibuf_pop); end
      tick();
      drive(0, 0, 30'h0, 0);
      chks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL fpp_refused: got v=%b want 0", out_valid); end
      tick();
   endtask

   task automatic test_stall();
      int ws [5] = '{0, 1, 3, 0, 1};
      do_reset();
      drive(1, 2, 30'h500, 0); tick();
      for (int k = 0; k < 5; k++) begin
         drive(1, ws[k], 30'h510 + 30'(k), 0);
         chks++; if (out_valid !== 1'b1 || out_wid !== 2'd2 || out_pc !== 30'h500 || ibuf_pop !== 4'b0)
            begin errs++; $display("FAIL stall%0d: got v=%b wid=%0d pc=%h pop=%b want wid=2 pc=500 pop=0000", k, out_valid, out_wid, out_pc, ibuf_pop); end
         tick();
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int k = 0; k < 3; k++) begin drive(1, k, 30'h600 + 30'(k), 0); tick(); end
      drive(0, 0, 30'h0, 0);
      chks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL areset_pre: got %b want 1", out_valid); end
      #2 reset_n = 1'b0;
      #1;
      chks++; if (out_valid !== 1'b0 || empty_mask !== 4'hf)
         begin errs++; $display("FAIL areset_now: got v=%b empty=%b want v=0 empty=1111", out_valid, empty_mask); end
      model_reset();
      @(posedge clk);
      #1 reset_n = 1'b1;
      drive(1, 3, 30'h6a0, 0); tick();
      drive(0, 0, 30'h0, 1);
      chks++; if (out_valid !== 1'b1 || out_wid !== 2'd3 || out_pc !== 30'h6a0)
         begin errs++; $display("FAIL areset_after: got v=%b wid=%0d pc=%h want wid=3 pc=6a0", out_valid, out_wid, out_pc); end
      tick();
   endtask

`ifdef IBUF_BYPASS_EN
   task automatic test_bypass();
      do_reset();
      drive(1, 3, 30'h700, 1);
      chks++; if (out_valid !== 1'b1 || out_wid !== 2'd3 || out_pc !== 30'h700 || ibuf_pop !== 4'b1000)
         begin errs++; $display("FAIL bypass_same: got v=%b wid=%0d pc=%h pop=%b want wid=3 pc=700 pop=1000", out_valid, out_wid, out_pc, ibuf_pop); end
      tick();
      drive(0, 0, 30'h0, 0);
      chks++; if (empty_mask !== 4'hf) begin errs++; $display("FAIL bypass_empty: got %b want 1111", empty_mask); end
      tick();
   endtask
`endif

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 9) < 6, $urandom_range(0, 3), 30'($urandom), $urandom_range(0, 9) < 4);
         chks++; if (out_valid !== e_valid) begin errs++; $display("FAIL rnd_valid@%0d: got %b want %b", n, out_valid, e_valid); end
         if (e_valid) begin
            chks++; if (out_wid !== 2'(e_wid)) begin errs++; $display("FAIL rnd_wid@%0d: got %0d want %0d", n, out_wid, e_wid); end
            chks++; if (out_data !== e_data) begin errs++; $display("FAIL rnd_data@%0d: got %h want %h", n, out_data, e_data); end
         end
         chks++; if (ibuf_pop !== e_ibuf) begin errs++; $display("FAIL rnd_pop@%0d: got %b want %b", n, ibuf_pop, e_ibuf); end
         chks++; if (empty_mask !== e_empty) begin errs++; $display("FAIL rnd_empty@%0d: got %b want %b", n, empty_mask, e_empty); end
         chks++; if (in_ready !== e_ready) begin errs++; $display("FAIL rnd_ready@%0d: got %b want %b", n, in_ready, e_ready); end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_rr();
      test_full_push_pop();
      test_stall();
      test_async_reset();
`ifdef IBUF_BYPASS_EN
      test_bypass();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, chks);
      $finish;
   end
endmodule
